// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer: synchronises an external request, waits for a safe
// pipeline point, drains fetch, then pushes PC, pushes flags and vectors.
module interrupt_controller #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [15:0] VECTOR_ADDR  = 16'h0002
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_int_req,
  input  logic        i_enable,
  input  logic        i_pipe_busy,
  input  logic        i_rti,
  output logic        o_interrupt,
  output logic        o_stall_fetch,
  output logic        o_push_pc,
  output logic        o_push_flags,
  output logic        o_load_pc,
  output logic [15:0] o_pc_value,
  output logic        o_in_service,
  output logic        o_pending
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_PC,
    S_PUSH_FLAGS,
    S_VECTOR,
    S_SERVICE
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       s1_q, s2_q, s3_q;
  logic       rise;
  logic       go;

  // s1/s2 form the two-flop synchroniser; s3 is the edge-detect history.
  assign rise = s2_q & ~s3_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pending_q <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      s1_q      <= i_int_req;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    go        = (state_q == S_IDLE) & pending_q & i_enable & ~i_pipe_busy;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 4'd0) state_d = S_PUSH_PC;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_PUSH_PC:    state_d = S_PUSH_FLAGS;
      S_PUSH_FLAGS: state_d = S_VECTOR;
      S_VECTOR:     state_d = S_SERVICE;
      S_SERVICE:    if (i_rti) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    // A new rise in the same cycle as entry must not be lost.
    if (go)   pending_d = 1'b0;
    if (rise) pending_d = 1'b1;
  end

  always_comb begin
    o_interrupt   = 1'b0;
    o_stall_fetch = 1'b0;
    o_push_pc     = 1'b0;
    o_push_flags  = 1'b0;
    o_load_pc     = 1'b0;
    o_pc_value    = 16'h0000;
    o_in_service  = 1'b0;
    case (state_q)
      S_DRAIN: begin
        o_interrupt   = 1'b1;
        o_stall_fetch = 1'b1;
      end
      S_PUSH_PC: begin
        o_interrupt   = 1'b1;
        o_stall_fetch = 1'b1;
        o_push_pc     = 1'b1;
      end
      S_PUSH_FLAGS: begin
        o_interrupt   = 1'b1;
        o_stall_fetch = 1'b1;
        o_push_flags  = 1'b1;
      end
      S_VECTOR: begin
        o_interrupt = 1'b1;
        o_load_pc   = 1'b1;
        o_pc_value  = VECTOR_ADDR;
      end
      S_SERVICE: o_in_service = 1'b1;
      default: ;
    endcase
  end

  assign o_pending = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: phase-count reference model compared every
// cycle, plus directed literal expectations for each scenario.
module tb_interrupt_controller;

  localparam int          D   = 3;
  localparam logic [15:0] VEC = 16'h0002;

  logic        clk, rst, req, en, busy, rti;
  logic        o_interrupt, o_stall_fetch, o_push_pc, o_push_flags;
  logic        o_load_pc, o_in_service, o_pending;
  logic [15:0] o_pc_value;

  int checks   = 0;
  int failures = 0;
  int npush    = 0;

  interrupt_controller #(.DRAIN_CYCLES(D), .VECTOR_ADDR(VEC)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_int_req    (req),
    .i_enable     (en),
    .i_pipe_busy  (busy),
    .i_rti        (rti),
    .o_interrupt  (o_interrupt),
    .o_stall_fetch(o_stall_fetch),
    .o_push_pc    (o_push_pc),
    .o_push_flags (o_push_flags),
    .o_load_pc    (o_load_pc),
    .o_pc_value   (o_pc_value),
    .o_in_service (o_in_service),
    .o_pending    (o_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: phase -1 = idle, 0..D-1 = drain, D = push PC,
  // D+1 = push flags, D+2 = vector, D+3 = in service.
  int m_phase;
  bit m_pend, h0, h1, h2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= -1;
      m_pend  <= 1'b0;
      h0 <= 1'b0; h1 <= 1'b0; h2 <= 1'b0;
    end else begin
      h0 <= req; h1 <= h0; h2 <= h1;
      if (m_phase < 0) begin
        if (m_pend && en && !busy) m_phase <= 0;
      end else if (m_phase < D + 3) begin
        m_phase <= m_phase + 1;
      end else if (rti) begin
        m_phase <= -1;
      end
      if (h1 && !h2) m_pend <= 1'b1;
      else if (m_phase < 0 && m_pend && en && !busy) m_pend <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    bit m_load;
    m_load = (m_phase == D + 2);
    chk("m_interrupt", {15'd0, o_interrupt},   {15'd0, (m_phase >= 0 && m_phase <= D + 2)});
    chk("m_stall",     {15'd0, o_stall_fetch}, {15'd0, (m_phase >= 0 && m_phase <= D + 1)});
    chk("m_push_pc",   {15'd0, o_push_pc},     {15'd0, (m_phase == D)});
    chk("m_push_flags",{15'd0, o_push_flags},  {15'd0, (m_phase == D + 1)});
    chk("m_load_pc",   {15'd0, o_load_pc},     {15'd0, m_load});
    chk("m_pc_value",  o_pc_value,             m_load ? VEC : 16'h0000);
    chk("m_in_service",{15'd0, o_in_service},  {15'd0, (m_phase == D + 3)});
    chk("m_pending",   {15'd0, o_pending},     {15'd0, m_pend});
  endtask

  task automatic step();
    @(negedge clk);
    if (o_push_pc) npush++;
    cmp_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_int"},   {15'd0, o_interrupt},   16'd0);
    chk({tag, "_stall"}, {15'd0, o_stall_fetch}, 16'd0);
    chk({tag, "_push"},  {15'd0, o_push_pc},     16'd0);
    chk({tag, "_flags"}, {15'd0, o_push_flags},  16'd0);
    chk({tag, "_load"},  {15'd0, o_load_pc},     16'd0);
    chk({tag, "_pc"},    o_pc_value,             16'd0);
    chk({tag, "_svc"},   {15'd0, o_in_service},  16'd0);
    chk({tag, "_pend"},  {15'd0, o_pending},     16'd0);
  endtask

  task automatic pulse_rti();
    rti = 1'b1;
    step();
    rti = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; en = 1'b0; busy = 1'b0; rti = 1'b0;
    steps(2);
    chk_all_zero("reset");
    rst = 1'b0;
    steps(2);

    // Basic entry: request visible from edge 0
    req = 1'b1; en = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      step();
      case (c)
        1: chk("basic_no_pend_c1", {15'd0, o_pending}, 16'd0);
        2: begin
             chk("basic_pend_c2", {15'd0, o_pending}, 16'd1);
             chk("basic_idle_c2", {15'd0, o_interrupt}, 16'd0);
           end
        3: begin
             chk("basic_stall_c3", {15'd0, o_stall_fetch}, 16'd1);
             chk("basic_pend_clr_c3", {15'd0, o_pending}, 16'd0);
           end
        5: chk("basic_stall_c5", {15'd0, o_stall_fetch}, 16'd1);
        6: chk("basic_push_pc_c6", {15'd0, o_push_pc}, 16'd1);
        7: chk("basic_push_fl_c7", {15'd0, o_push_flags}, 16'd1);
        8: begin
             chk("basic_load_c8", {15'd0, o_load_pc}, 16'd1);
             chk("basic_vec_c8", o_pc_value, 16'h0002);
           end
        9: chk("basic_svc_c9", {15'd0, o_in_service}, 16'd1);
        default: ;
      endcase
    end
    req = 1'b0;
    pulse_rti();
    chk("basic_rti_idle", {15'd0, o_in_service}, 16'd0);
    steps(3);

    // Busy gating
    busy = 1'b1; req = 1'b1;
    steps(3);
    chk("busy_pend", {15'd0, o_pending}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy_hold_int", {15'd0, o_interrupt}, 16'd0);
    end
    busy = 1'b0;
    step();
    chk("busy_release_drain", {15'd0, o_stall_fetch}, 16'd1);
    req = 1'b0;
    steps(D + 3);
    chk("busy_svc", {15'd0, o_in_service}, 16'd1);

    // Request during service: latched, no nesting
    steps(2);
    req = 1'b1;
    steps(3);
    chk("svc_req_pend", {15'd0, o_pending}, 16'd1);
    chk("svc_req_noint", {15'd0, o_interrupt}, 16'd0);
    chk("svc_req_still_svc", {15'd0, o_in_service}, 16'd1);
    pulse_rti();
    chk("svc_rti_idle_int", {15'd0, o_interrupt}, 16'd0);
    chk("svc_rti_idle_svc", {15'd0, o_in_service}, 16'd0);
    step();
    chk("svc_next_drain", {15'd0, o_stall_fetch}, 16'd1);
    req = 1'b0;
    steps(D + 3);
    pulse_rti();
    steps(2);

    // Disable hold, spurious RTI, disable mid-sequence
    en = 1'b0; req = 1'b1;
    steps(22);
    chk("dis_pend", {15'd0, o_pending}, 16'd1);
    chk("dis_noint", {15'd0, o_interrupt}, 16'd0);
    pulse_rti();
    step();
    chk("spur_rti_pend", {15'd0, o_pending}, 16'd1);
    chk("spur_rti_noint", {15'd0, o_interrupt}, 16'd0);
    en = 1'b1;
    step();
    chk("en_drain", {15'd0, o_stall_fetch}, 16'd1);
    en = 1'b0;
    steps(D);
    chk("en_off_push_pc", {15'd0, o_push_pc}, 16'd1);
    steps(3);
    chk("en_off_svc", {15'd0, o_in_service}, 16'd1);
    req = 1'b0; en = 1'b1;
    pulse_rti();
    steps(3);

    // Asynchronous reset mid-drain
    req = 1'b1;
    steps(4);
    chk("rst_pre_drain", {15'd0, o_stall_fetch}, 16'd1);
    #2 rst = 1'b1; req = 1'b0;
    #1 chk_all_zero("rst_async");
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_after_noint", {15'd0, o_interrupt}, 16'd0);
    end

    // Merge: two rises while held by busy
    busy = 1'b1;
    req = 1'b1; steps(2);
    req = 1'b0; steps(2);
    req = 1'b1; steps(2);
    steps(3);
    chk("merge_pend", {15'd0, o_pending}, 16'd1);
    npush = 0;
    busy = 1'b0;
    steps(15);
    chk("merge_one_seq", npush[15:0], 16'd1);
    chk("merge_pend_clr", {15'd0, o_pending}, 16'd0);
    chk("merge_svc", {15'd0, o_in_service}, 16'd1);
    req = 1'b0;
    pulse_rti();
    steps(5);
    chk("merge_no_second", npush[15:0], 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
